// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM keypad front-end.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CONFIRM,
    ST_GRANTED,
    ST_LOCKED
  } atm_state_t;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_BACK   = 4'hB;
  localparam logic [3:0] KEY_ENTER  = 4'hC;
  localparam logic [3:0] KEY_CANCEL = 4'hD;

  localparam int unsigned DEF_DIGITS    = 3;
  localparam int unsigned DEF_MAX_TRIES = 3;

endpackage

// File: rtl/atm_idle_timer.sv
// Inactivity counter: held clear while not running, reloaded by activity,
// saturates at its last value and flags expiry unless reloaded that cycle.
module atm_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic reload,
  output logic expire
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || reload) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = run && !reload && (cnt == LAST);

endmodule

// File: rtl/atm_pin_entry.sv
// Keypad PIN collector: gathers BCD digits, presents them with LC, tracks
// controller verdicts, failed attempts, lockout and inactivity timeout.
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int unsigned DIGITS         = DEF_DIGITS,
  parameter int unsigned MAX_TRIES      = DEF_MAX_TRIES,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               card_in,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  input  logic                               auth_done,
  input  logic                               auth_ok,
  output logic [4*DIGITS-1:0]                PIN,
  output logic                               LC,
  output logic [$clog2(DIGITS+1)-1:0]        digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic                               timeout,
  output logic                               auth_failed,
  output logic                               granted,
  output logic                               card_locked
);
  localparam int unsigned PW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam logic [CW-1:0] DIG_C = CW'(DIGITS);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_TRIES);

  atm_state_t state_q, state_n;
  logic [PW-1:0] pin_q, pin_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [TW-1:0] tries_q, tries_n;
  logic          timeout_q, timeout_n;
  logic          failed_q, failed_n;
  logic          lc_q, granted_q, locked_q;
  logic          expire;

  atm_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state_q == ST_COLLECT),
    .reload (key_valid),
    .expire (expire)
  );

  always_comb begin
    state_n   = state_q;
    pin_n     = pin_q;
    cnt_n     = cnt_q;
    tries_n   = tries_q;
    timeout_n = 1'b0;
    failed_n  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pin_n   = '0;
        cnt_n   = '0;
        tries_n = MAX_T;
        if (card_in) state_n = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!card_in) begin
          state_n = ST_IDLE;
        end else if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (cnt_q < DIG_C) begin
              pin_n = {pin_q[PW-5:0], key_code};
              cnt_n = cnt_q + CW'(1);
            end
          end else begin
            case (key_code)
              KEY_CLEAR: begin
                pin_n = '0;
                cnt_n = '0;
              end
              KEY_BACK: begin
                if (cnt_q != '0) begin
                  pin_n = pin_q >> 4;
                  cnt_n = cnt_q - CW'(1);
                end
              end
              KEY_ENTER:  if (cnt_q == DIG_C) state_n = ST_CONFIRM;
              KEY_CANCEL: state_n = ST_IDLE;
              default: ;
            endcase
          end
        end else if (expire) begin
          timeout_n = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_CONFIRM: begin
        if (!card_in) begin
          state_n = ST_IDLE;
        end else if (auth_done) begin
          if (auth_ok) begin
            state_n = ST_GRANTED;
          end else begin
            failed_n = 1'b1;
            tries_n  = tries_q - TW'(1);
            if (tries_q == TW'(1)) begin
              state_n = ST_LOCKED;
            end else begin
              state_n = ST_COLLECT;
              pin_n   = '0;
              cnt_n   = '0;
            end
          end
        end
      end
      ST_GRANTED: if (!card_in) state_n = ST_IDLE;
      ST_LOCKED:  ;
      default:    state_n = ST_IDLE;
    endcase
    // Every path into IDLE clears the session so outputs drop on the same edge.
    if (state_n == ST_IDLE) begin
      pin_n   = '0;
      cnt_n   = '0;
      tries_n = MAX_T;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pin_q     <= '0;
      cnt_q     <= '0;
      tries_q   <= MAX_T;
      timeout_q <= 1'b0;
      failed_q  <= 1'b0;
      lc_q      <= 1'b0;
      granted_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      pin_q     <= pin_n;
      cnt_q     <= cnt_n;
      tries_q   <= tries_n;
      timeout_q <= timeout_n;
      failed_q  <= failed_n;
      lc_q      <= (state_n == ST_CONFIRM);
      granted_q <= (state_n == ST_GRANTED);
      locked_q  <= (state_n == ST_LOCKED);
    end
  end

  assign PIN         = pin_q;
  assign LC          = lc_q;
  assign digit_count = cnt_q;
  assign tries_left  = tries_q;
  assign timeout     = timeout_q;
  assign auth_failed = failed_q;
  assign granted     = granted_q;
  assign card_locked = locked_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Scoreboarded bench for atm_pin_entry: expected PIN words queued at enter,
// compared when LC rises; direct checks for counters, pulses and lockout.
module tb_atm_pin_entry;
  localparam int unsigned TO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        card_in = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        auth_done = 1'b0;
  logic        auth_ok = 1'b0;
  logic [11:0] PIN;
  logic        LC;
  logic [1:0]  digit_count;
  logic [1:0]  tries_left;
  logic        timeout;
  logic        auth_failed;
  logic        granted;
  logic        card_locked;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] m_pin = '0;
  int unsigned m_cnt = 0;
  logic        lc_prev = 1'b0;

  atm_pin_entry #(.DIGITS(3), .MAX_TRIES(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid),
    .key_code(key_code), .auth_done(auth_done), .auth_ok(auth_ok),
    .PIN(PIN), .LC(LC), .digit_count(digit_count), .tries_left(tries_left),
    .timeout(timeout), .auth_failed(auth_failed), .granted(granted),
    .card_locked(card_locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // LC rising edge is where the DUT presents a PIN; match it against the queue.
  always @(negedge clk) begin
    if (LC && !lc_prev) begin
      if (exp_q.size() == 0) check_eq("lc_unexpected", 32'(LC), 32'd0);
      else check_eq("lc_pin", 32'(PIN), 32'(exp_q.pop_front()));
    end
    lc_prev <= LC;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pin = '0;
    m_cnt = 0;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    if (k <= 4'd9) begin
      if (m_cnt < 3) begin
        m_pin = {m_pin[7:0], k};
        m_cnt++;
      end
    end else if (k == 4'hA) begin
      model_reset();
    end else if (k == 4'hB) begin
      if (m_cnt > 0) begin
        m_pin = {4'h0, m_pin[11:4]};
        m_cnt--;
      end
    end else if (k == 4'hC) begin
      if (m_cnt == 3) exp_q.push_back(m_pin);
    end
    tick();
    key_valid = 1'b0;
    if (k != 4'hC) begin
      check_eq("key_pin", 32'(PIN), 32'(m_pin));
      check_eq("key_cnt", 32'(digit_count), m_cnt);
    end
  endtask

  task automatic verdict(input logic ok);
    auth_done = 1'b1;
    auth_ok   = ok;
    tick();
    auth_done = 1'b0;
    auth_ok   = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, "_pin"}, 32'(PIN), 32'd0);
    check_eq({tag, "_lc"}, 32'(LC), 32'd0);
    check_eq({tag, "_cnt"}, 32'(digit_count), 32'd0);
    check_eq({tag, "_tries"}, 32'(tries_left), 32'd3);
    check_eq({tag, "_to"}, 32'(timeout), 32'd0);
    check_eq({tag, "_af"}, 32'(auth_failed), 32'd0);
    check_eq({tag, "_gr"}, 32'(granted), 32'd0);
    check_eq({tag, "_lk"}, 32'(card_locked), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    // Basic accept path
    card_in = 1'b1;
    tick();
    model_reset();
    press(4'h1); press(4'h2); press(4'h3); press(4'hC);
    check_eq("lc_after_enter", 32'(LC), 32'd1);
    check_eq("pin_123", 32'(PIN), 32'h123);
    verdict(1'b1);
    check_eq("granted", 32'(granted), 32'd1);
    check_eq("lc_drop", 32'(LC), 32'd0);
    press(4'h5);
    check_eq("granted_keys_ignored", 32'(granted), 32'd1);
    card_in = 1'b0;
    tick();
    check_eq("granted_clear", 32'(granted), 32'd0);

    // Backspace frees a slot; card pulled in the verdict cycle
    card_in = 1'b1;
    tick();
    model_reset();
    press(4'h4); press(4'h5); press(4'hB); press(4'h6); press(4'h7); press(4'hC);
    check_eq("lc_467", 32'(LC), 32'd1);
    check_eq("pin_467", 32'(PIN), 32'h467);
    card_in   = 1'b0;
    auth_done = 1'b1;
    auth_ok   = 1'b1;
    tick();
    auth_done = 1'b0;
    auth_ok   = 1'b0;
    check_eq("pull_granted", 32'(granted), 32'd0);
    check_eq("pull_lc", 32'(LC), 32'd0);
    check_eq("pull_pin", 32'(PIN), 32'd0);

    // Short enter ignored, then three rejections to lockout
    card_in = 1'b1;
    tick();
    model_reset();
    press(4'h1); press(4'h2); press(4'hC);
    check_eq("short_enter_lc", 32'(LC), 32'd0);
    press(4'hA);
    for (int r = 0; r < 3; r++) begin
      press(4'h9); press(4'h9); press(4'h9); press(4'hC);
      check_eq("rej_lc", 32'(LC), 32'd1);
      verdict(1'b0);
      model_reset();
      check_eq("rej_pulse", 32'(auth_failed), 32'd1);
      check_eq("rej_tries", 32'(tries_left), 32'(2 - r));
      check_eq("rej_locked", 32'(card_locked), (r == 2) ? 32'd1 : 32'd0);
      check_eq("rej_lc_drop", 32'(LC), 32'd0);
      tick();
      check_eq("rej_pulse_end", 32'(auth_failed), 32'd0);
    end
    card_in = 1'b0;
    tick();
    tick();
    check_eq("locked_after_pull", 32'(card_locked), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("unlock");

    // Timeout after inactivity, then a key landing on the expiry cycle
    card_in = 1'b1;
    tick();
    model_reset();
    press(4'h5);
    for (int i = 0; i < TO - 1; i++) tick();
    check_eq("pre_timeout", 32'(timeout), 32'd0);
    tick();
    model_reset();
    check_eq("timeout_pulse", 32'(timeout), 32'd1);
    check_eq("timeout_cnt", 32'(digit_count), 32'd0);
    tick();
    check_eq("timeout_end", 32'(timeout), 32'd0);
    press(4'h5);
    for (int i = 0; i < TO - 1; i++) tick();
    press(4'h6);
    check_eq("key_beats_timeout", 32'(timeout), 32'd0);
    for (int i = 0; i < TO - 1; i++) tick();
    check_eq("pre_timeout2", 32'(timeout), 32'd0);
    tick();
    model_reset();
    check_eq("timeout_pulse2", 32'(timeout), 32'd1);
    tick();

    // Reset in the middle of collection
    press(4'h3); press(4'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");

    tick();
    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/atm_pin_entry.md
# atm_pin_entry

Keypad front-end that sits directly upstream of the ATM controller. It collects three decimal key presses into the 12-bit `PIN` word and presents it to the controller with the `LC` load/confirm strobe. It then waits for the controller's authorization verdict, counts failed attempts, and locks the card after too many failures. It also enforces an inactivity timeout and handles clear, backspace and cancel keys.

## Interface
- `DIGITS`, 3: number of BCD digits per PIN; `PIN` width = 4*DIGITS.
- `MAX_TRIES`, 3: failed attempts allowed before lockout.
- `TIMEOUT_CYCLES`, 1024: idle cycles in COLLECT before abort.

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset is synchronous and active-high.
- `card_in` in 1: level; card present.
- `key_valid` in 1: one-cycle key strobe.
- `key_code` in 4: 0–9 digit, A clear, B backspace, C enter, D cancel, E/F ignored.
- `auth_done` in 1: one-cycle verdict strobe from the controller.
- `auth_ok` in 1: verdict, sampled only with `auth_done`.
- `PIN` out 12: packed BCD, first digit in [11:8].
- `LC` out 1: level; PIN valid and awaiting verdict.
- `digit_count` out 2: digits entered (0..DIGITS).
- `tries_left` out 2: remaining attempts.
- `timeout` out 1: one-cycle pulse on inactivity abort.
- `auth_failed` out 1: one-cycle pulse per rejected PIN.
- `granted` out 1: level; session authorized.
- `card_locked` out 1: level; lockout.

## Operation
- States: IDLE, COLLECT, CONFIRM, GRANTED, LOCKED.
- IDLE: outputs cleared. `card_in`=1 → COLLECT, with `tries_left`←MAX_TRIES, `PIN`←0, `digit_count`←0, timer cleared.
- COLLECT key handling:
  - Digit with `digit_count`<DIGITS: `PIN`←{PIN[7:0],digit}, count+1.
  - Digit when full: ignored.
  - A: `PIN`←0, count←0.
  - B: `PIN`←PIN>>4, count−1. No-op at count 0.
  - C: accepted only when count==DIGITS, → CONFIRM. Otherwise ignored.
  - D: → IDLE.
  - E/F: ignored, but still reload the timer.
- CONFIRM: `LC`=1. `PIN` frozen. Keys ignored. Timer is not running.
  - `auth_done`&`auth_ok` → GRANTED.
  - `auth_done`&!`auth_ok`: `auth_failed` pulse, `tries_left`−1.
    - Result 0 → LOCKED.
    - Otherwise → COLLECT with `PIN`/count cleared.
- GRANTED: `granted`=1. Keys ignored. Stays until card removed.
- LOCKED: `card_locked`=1. Ignores all inputs including `card_in`. Exits only on `rst`.
- Card removal: `card_in`=0 in COLLECT, CONFIRM or GRANTED → IDLE next cycle, outputs cleared. This overrides key and `auth_done` in the same cycle.
- `auth_done` outside CONFIRM: ignored.
- Timeout: counter reloads on any `key_valid` in COLLECT. If it reaches TIMEOUT_CYCLES−1 with no key that cycle, then `timeout` pulses and the state goes to IDLE. A key in the expiry cycle wins and reloads the counter.

## Timing
- Reset values: `PIN`=0, `LC`=0, `digit_count`=0, `tries_left`=MAX_TRIES, `timeout`=0, `auth_failed`=0, `granted`=0, `card_locked`=0. State = IDLE.
- All outputs are registered.
- Key sampled at edge N → `PIN`/`digit_count` updated after edge N.
- Enter at edge N → `LC`=1 from edge N+1. `LC` holds until the edge that samples `auth_done`, then drops after that edge.
- `auth_failed`/`timeout` are high for exactly one cycle, coincident with the state change.
- Minimum insertion-to-`LC` latency is DIGITS+2 cycles: 1 for the IDLE→COLLECT transition, then DIGITS digit cycles, then 1 for enter.
- `rst` mid-operation: all registers return to reset values on that edge, including exit from LOCKED.

## Structure
- Shared package `atm_pkg`:
  - State enum.
  - Key code constants (KEY_CLEAR=4'hA, KEY_BACK=4'hB, KEY_ENTER=4'hC, KEY_CANCEL=4'hD).
  - Default DIGITS/MAX_TRIES.
- One sub-module, `atm_idle_timer`: ports `clk`/`rst`/`run`/`reload`/`expire`. Width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Insert card, keys 1,2,3,C → `PIN`=12'h123, `LC`=1. `auth_done`+`auth_ok` → `granted`=1, `LC`=0.
- Keys 4,5,B,6,7,C → `PIN`=12'h467. The 7 is accepted because B freed a slot, so count=3 before C. Keys 1,2,C with count 2 → no `LC`.
- Three rejections of 12'h999 → `tries_left` steps 2,1,0 with three `auth_failed` pulses, then `card_locked`=1. Subsequent card removal leaves LOCKED; only `rst` clears it.
- One key, then TIMEOUT_CYCLES−1 idle cycles → `timeout` pulse, IDLE. Repeat with a key landing on the expiry cycle → no timeout.
- `card_in` dropped in the same cycle as `auth_done`&`auth_ok` in CONFIRM → IDLE, `granted` stays 0. `rst` asserted mid-COLLECT → all outputs at reset values next cycle.
